// File: rtl/seq_pkg.sv
// Shared types and default sizing for the stage sequencer.
package seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      RELEASE,
      DONE
   } seq_state_t;

   localparam int N_STAGES_DEF = 8;
   localparam int TIMEOUT_DEF  = 1024;
   localparam int CNT_W_DEF    = 16;
   localparam int IDX_W        = 4;

endpackage

// File: rtl/seq_timer.sv
// Loadable up-counter; tc is high once the count reaches LIMIT-1, where it holds.
module seq_timer #(
   parameter int LIMIT = seq_pkg::TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic tc
);

   localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || load)
         count <= '0;
      else if (en && !tc)
         count <= count + 1'b1;
   end

   assign tc = (count == W'(LIMIT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// Drives the start/finish handshake of each stage in turn, recording the first
// failure and the elapsed cycle count of the run.
module stage_sequencer
   import seq_pkg::*;
#(
   parameter int N_STAGES = N_STAGES_DEF,
   parameter int TIMEOUT  = TIMEOUT_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                go,
   input  logic                abort,
   input  logic [N_STAGES-1:0] finish,
   input  logic [N_STAGES-1:0] pass,
   output logic [N_STAGES-1:0] start,
   output logic                busy,
   output logic                done,
   output logic                fail,
   output logic [3:0]          fail_stage,
   output logic [CNT_W-1:0]    cycles
);

   seq_state_t          state, state_nx;
   logic [IDX_W-1:0]    idx;
   logic [N_STAGES-1:0] idx_mask;
   logic                sel_finish, sel_pass, last_stage;
   logic                run_clr, idx_inc, set_fail;
   logic                timer_load, timer_en, timer_tc;

   always_comb begin
      idx_mask = '0;
      for (int unsigned i = 0; i < N_STAGES; i++)
         idx_mask[i] = (idx == IDX_W'(i));
   end

   // Only the selected stage's finish/pass bits can influence the run.
   assign sel_finish = |(finish & idx_mask);
   assign sel_pass   = |(pass & idx_mask);
   assign last_stage = (idx == IDX_W'(N_STAGES - 1));

   seq_timer #(
      .LIMIT(TIMEOUT)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .load(timer_load),
      .en  (timer_en),
      .tc  (timer_tc)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      run_clr    = 1'b0;
      idx_inc    = 1'b0;
      set_fail   = 1'b0;
      timer_load = 1'b0;
      timer_en   = 1'b0;
      start      = '0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (go) begin
               state_nx = ISSUE;
               run_clr  = 1'b1;
            end
         end
         ISSUE: begin
            busy = 1'b1;
            if (abort) begin
               state_nx = DONE;
               set_fail = 1'b1;
            end else begin
               state_nx   = WAIT;
               timer_load = 1'b1;
            end
         end
         WAIT: begin
            busy  = 1'b1;
            start = idx_mask;
            if (abort) begin
               state_nx = DONE;
               set_fail = 1'b1;
            end else if (sel_finish) begin
               state_nx = RELEASE;
               set_fail = !sel_pass;
            end else if (timer_tc) begin
               state_nx = RELEASE;
               set_fail = 1'b1;
            end else begin
               timer_en = 1'b1;
            end
         end
         RELEASE: begin
            busy = 1'b1;
            if (abort) begin
               state_nx = DONE;
               set_fail = 1'b1;
            end else if (!sel_finish) begin
               if (last_stage) begin
                  state_nx = DONE;
               end else begin
                  state_nx = ISSUE;
                  idx_inc  = 1'b1;
               end
            end
         end
         DONE: begin
            done = 1'b1;
            if (go) begin
               state_nx = ISSUE;
               run_clr  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         fail       <= 1'b0;
         fail_stage <= '0;
         cycles     <= '0;
      end else if (run_clr) begin
         idx        <= '0;
         fail       <= 1'b0;
         fail_stage <= '0;
         cycles     <= '0;
      end else begin
         if (idx_inc)
            idx <= idx + 1'b1;
         // First failure wins; later failures leave fail_stage untouched.
         if (set_fail && !fail) begin
            fail       <= 1'b1;
            fail_stage <= idx;
         end
         if (busy && (cycles != '1))
            cycles <= cycles + 1'b1;
      end
   end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Synthesizable initiator for the start/finish stage handshake used by the unit-test chain (dm, im, ifu, alu, ext, gpr, instruction, p1 stages).
- Drives one stage at a time, waits for its finish, records pass/fail and cycle count, then advances.
- Sits beside mips in the on-chip self-test harness and replaces daisy-chained start wiring with a single controlled sequencer.

Parameters:
N_STAGES, 8, number of stages driven (1..16)
TIMEOUT, 1024, max cycles a stage may hold off finish before it is failed
CNT_W, 16, width of the per-run elapsed-cycle counter (saturating)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
go  in  1  one-cycle pulse; begins a run when in IDLE or DONE
abort  in  1  level; forces the run to end with error
finish  in  N_STAGES  per-stage finish level from stage under test
pass  in  N_STAGES  per-stage result, sampled in the cycle finish is first seen high
start  out  N_STAGES  one-hot start level to stage under test
busy  out  1  high from ISSUE through RELEASE
done  out  1  high in DONE, cleared by go or rst
fail  out  1  sticky: any stage failed, timed out, or the run was aborted
fail_stage  out  4  index of the first failing stage (valid when fail=1)
cycles  out  CNT_W  total cycles since the run started, saturating at all-ones

Behaviour:
- Reset: start=0, busy=0, done=0, fail=0, fail_stage=0, cycles=0, state=IDLE, idx=0, timer=0.
- States:
  - IDLE: go -> ISSUE, idx=0, cycles=0, fail=0. Otherwise hold.
  - ISSUE: start[idx]=1 from the next cycle. Go to WAIT, timer=0.
  - WAIT: start[idx] held high.
    - finish[idx]=1: latch pass[idx]. If it is 0 and fail=0, set fail=1 and fail_stage=idx. Go to RELEASE.
    - timer==TIMEOUT-1 with no finish: fail=1, fail_stage=idx if not already set. Go to RELEASE.
    - Otherwise timer++.
  - RELEASE: start=0. Wait for finish[idx]=0, which may already be 0. Then, if idx==N_STAGES-1 -> DONE, else idx++ -> ISSUE. The finish-low wait has no timeout; abort is the only exit.
  - DONE: done=1, busy=0. go -> ISSUE, clearing done, fail, fail_stage and cycles, with idx=0.
- abort: has priority over every transition except rst. In ISSUE, WAIT or RELEASE it sets start=0, fail=1, fail_stage=idx if fail was 0, and goes to DONE. In IDLE or DONE it is ignored.
- go outside IDLE/DONE is ignored.
- Invariant: start is all-zero or exactly one-hot, and no two stages are ever started in the same cycle.
- There is at least one cycle with start=0 between consecutive stages.
- cycles increments every cycle while busy=1, saturates at 2^CNT_W-1 and does not wrap.
- finish or pass bits of non-selected stages are ignored.
- Minimum stage latency: ISSUE(1) + WAIT(1 when finish is already high) + RELEASE(1) = 3 cycles per stage.
- rst mid-run: returns to IDLE within one cycle and start drops on the next edge.

Decomposition:
- Package seq_pkg holds the state enum (IDLE, ISSUE, WAIT, RELEASE, DONE) and the default constants N_STAGES_DEF and TIMEOUT_DEF.
- One natural sub-module: seq_timer, a loadable up-counter with a terminal-count flag, instanced for the WAIT timeout. The cycles counter stays inline.

Test Plan:
- All pass, N_STAGES=8, each stage responds 2 cycles after start -> start walks 0x01..0x80 one-hot with gaps, done=1, fail=0, cycles=40.
- Stage 3 returns pass=0 and stage 5 also fails -> fail=1, fail_stage=3 (first failure kept), run continues to done=1.
- Stage 2 never asserts finish, TIMEOUT=16 -> after 16 WAIT cycles fail=1, fail_stage=2, start[2] drops, and the sequence continues to stage 3.
- abort asserted in WAIT on stage 4 -> next cycle start=0, done=1, fail=1, fail_stage=4; a following go restarts at stage 0 with fail cleared.
- rst asserted mid-WAIT on stage 6 -> next cycle all outputs are at reset values; a go pulse during rst is ignored.
- CNT_W=4 with slow stages -> cycles saturates at 15; a stage holding finish high for 5 cycles after start drops keeps RELEASE stalled and start stays 0.
